// File: rtl/fibre_a_spike_buffer.sv
// fibre_a_spike_buffer
// Ping-pong spike-word memory feeding the fibre_a read port of tppe.
// A loader fills the write bank while tppe reads the sealed read bank.
// A tile is sealed by wr_last on an accepted write. The consumer
// releases a sealed tile with tile_done.

module fibre_a_spike_buffer #(
    parameter int TIMESTEPS  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [TIMESTEPS-1:0]  wr_data,
    input  logic                  wr_last,
    input  logic                  fibre_a_read_en,
    input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
    output logic [TIMESTEPS-1:0]  fibre_a_data,
    output logic                  fibre_a_valid,
    input  logic                  tile_done,
    output logic                  read_bank_ready,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  addr_error
);

    // Word index width inside one bank; the address is range-checked
    // against DEPTH before the index is used, so the upper bits can go.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH at one bit wider than the address, so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    // Both banks; contents are deliberately left unreset.
    logic [TIMESTEPS-1:0] mem_r [0:1][0:DEPTH-1];

    logic [1:0]           full_r;
    logic                 wp_r;
    logic                 rp_r;
    logic                 addr_error_r;
    logic [TIMESTEPS-1:0] data_r;
    logic                 valid_r;

    logic [1:0]           full_n_s;
    logic                 wp_n_s;
    logic                 rp_n_s;
    logic                 err_n_s;
    logic [TIMESTEPS-1:0] data_n_s;
    logic                 valid_n_s;

    logic                 wr_acc_s;
    logic                 wr_in_range_s;
    logic                 rd_in_range_s;
    logic                 mem_we_s;
    logic                 release_s;
    logic [IDX_W-1:0]     wr_idx_s;
    logic [IDX_W-1:0]     rd_idx_s;
    logic [TIMESTEPS-1:0] rd_word_s;

    assign wr_ready       = ~full_r[wp_r];
    assign wr_acc_s       = wr_valid & wr_ready;
    assign wr_in_range_s  = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range_s  = ({1'b0, fibre_a_addr} < DEPTH_L);
    assign mem_we_s       = wr_acc_s & wr_in_range_s;
    // A release is only meaningful while the read bank holds a sealed tile.
    assign release_s      = tile_done & full_r[rp_r];
    assign wr_idx_s       = wr_addr[IDX_W-1:0];
    assign rd_idx_s       = fibre_a_addr[IDX_W-1:0];
    assign rd_word_s      = mem_r[rp_r][rd_idx_s];

    // Bank write port: store in-range words into the current write bank.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wp_r][wr_idx_s] <= wr_data;
        end
    end

    // Next-state logic for bank flags, pointers, read port and sticky error.
    always_comb begin
        full_n_s  = full_r;
        wp_n_s    = wp_r;
        rp_n_s    = rp_r;
        err_n_s   = addr_error_r;
        data_n_s  = data_r;
        valid_n_s = 1'b0;

        // Seal: an accepted write carrying wr_last closes the write bank.
        if (wr_acc_s && wr_last) begin
            full_n_s[wp_r] = 1'b1;
            wp_n_s         = ~wp_r;
        end else begin
            wp_n_s = wp_r;
        end

        // Release: when wp == rp the write side is stalled, so the seal
        // and the release never target the same bank in one cycle.
        if (release_s) begin
            full_n_s[rp_r] = 1'b0;
            rp_n_s         = ~rp_r;
        end else begin
            rp_n_s = rp_r;
        end

        if (wr_acc_s && !wr_in_range_s) begin
            err_n_s = 1'b1;
        end else begin
            err_n_s = err_n_s;
        end

        // Read uses the pre-release rp, so a read alongside tile_done
        // is served from the bank being released.
        if (fibre_a_read_en) begin
            if (!full_r[rp_r]) begin
                err_n_s = 1'b1;
            end else if (rd_in_range_s) begin
                data_n_s  = rd_word_s;
                valid_n_s = 1'b1;
            end else begin
                data_n_s  = {TIMESTEPS{1'b0}};
                valid_n_s = 1'b1;
                err_n_s   = 1'b1;
            end
        end else begin
            valid_n_s = 1'b0;
        end
    end

    // Control state and registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r       <= 2'b00;
            wp_r         <= 1'b0;
            rp_r         <= 1'b0;
            addr_error_r <= 1'b0;
            data_r       <= {TIMESTEPS{1'b0}};
            valid_r      <= 1'b0;
        end else begin
            full_r       <= full_n_s;
            wp_r         <= wp_n_s;
            rp_r         <= rp_n_s;
            addr_error_r <= err_n_s;
            data_r       <= data_n_s;
            valid_r      <= valid_n_s;
        end
    end

    assign fibre_a_data    = data_r;
    assign fibre_a_valid   = valid_r;
    assign read_bank_ready = full_r[rp_r];
    assign wr_bank         = wp_r;
    assign rd_bank         = rp_r;
    assign addr_error      = addr_error_r;

endmodule

// File: tb/tb_fibre_a_spike_buffer.sv
// Bench for fibre_a_spike_buffer: directed stimulus, read responses
// checked by a scoreboard monitor, status outputs checked inline.

module tb_fibre_a_spike_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       fibre_a_read_en;
    logic [7:0] fibre_a_addr;
    logic [7:0] fibre_a_data;
    logic       fibre_a_valid;
    logic       tile_done;
    logic       read_bank_ready;
    logic       wr_bank;
    logic       rd_bank;
    logic       addr_error;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    fibre_a_spike_buffer #(.TIMESTEPS(8), .ADDR_WIDTH(8), .DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last),
        .fibre_a_read_en(fibre_a_read_en), .fibre_a_addr(fibre_a_addr),
        .fibre_a_data(fibre_a_data), .fibre_a_valid(fibre_a_valid),
        .tile_done(tile_done), .read_bank_ready(read_bank_ready),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each expected read must appear exactly on its due cycle; any other valid is unexpected.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            vectors++;
            if (!fibre_a_valid || fibre_a_data !== sbq[0].data) begin
                miscompares++;
                $display("FAIL read_data cyc=%0d: got valid=%0b data=%02h, want valid=1 data=%02h",
                         cyc, fibre_a_valid, fibre_a_data, sbq[0].data);
            end
            void'(sbq.pop_front());
        end else if (fibre_a_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid cyc=%0d: got valid=1 data=%02h, want valid=0",
                     cyc, fibre_a_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic last);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_last = last;
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input bit exp_v, input logic [7:0] exp_d);
        exp_t e;
        fibre_a_read_en = 1'b1; fibre_a_addr = a;
        if (exp_v) begin
            e.due = cyc + 1; e.data = exp_d;
            sbq.push_back(e);
        end
        tick();
        fibre_a_read_en = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 8'h00; wr_last = 1'b0;
        fibre_a_read_en = 1'b0; fibre_a_addr = 8'h00; tile_done = 1'b0;
        tick(); tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rbr", 32'(read_bank_ready), 32'd0);
        check("rst_valid", 32'(fibre_a_valid), 32'd0);
        check("rst_data", 32'(fibre_a_data), 32'd0);
        check("rst_err", 32'(addr_error), 32'd0);
        check("rst_banks", {30'd0, wr_bank, rd_bank}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Tile 0: addr i -> data i.
        for (int i = 0; i < 128; i++) begin
            if (i == 127) check("rbr_before_seal", 32'(read_bank_ready), 32'd0);
            wr(8'(i), 8'(i), (i == 127));
        end
        check("rbr_after_seal", 32'(read_bank_ready), 32'd1);
        check("wr_bank_after_seal0", 32'(wr_bank), 32'd1);
        check("wr_ready_after_seal0", 32'(wr_ready), 32'd1);

        rd(8'd5, 1'b1, 8'h05);
        // Streaming reads with no gaps.
        for (int i = 0; i < 128; i++) rd(8'(i), 1'b1, 8'(i));

        // Tile 1: addr i -> 0xFF - i.
        for (int i = 0; i < 128; i++) begin
            if (i == 64) check("wr_ready_fill1", 32'(wr_ready), 32'd1);
            wr(8'(i), 8'(8'hFF - 8'(i)), (i == 127));
        end
        check("wr_ready_both_full", 32'(wr_ready), 32'd0);
        check("wr_bank_both_full", 32'(wr_bank), 32'd0);

        // Third-tile write held while stalled.
        wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 8'h77; wr_last = 1'b0;
        rd(8'd3, 1'b1, 8'h03);
        check("wr_ready_stalled", 32'(wr_ready), 32'd0);
        // Read together with tile_done: served from old bank 0.
        tile_done = 1'b1; fibre_a_read_en = 1'b1; fibre_a_addr = 8'd7;
        e.due = cyc + 1; e.data = 8'h07; sbq.push_back(e);
        tick();
        tile_done = 1'b0; fibre_a_read_en = 1'b0;
        check("rd_bank_after_release", 32'(rd_bank), 32'd1);
        check("wr_ready_after_release", 32'(wr_ready), 32'd1);
        check("rbr_bank1", 32'(read_bank_ready), 32'd1);
        tick();            // held write accepted into bank 0
        wr_valid = 1'b0;
        rd(8'd3, 1'b1, 8'hFC);

        // Seal bank 0 and release bank 1 in the same cycle.
        wr_valid = 1'b1; wr_addr = 8'd127; wr_data = 8'h11; wr_last = 1'b1; tile_done = 1'b1;
        tick();
        wr_valid = 1'b0; wr_last = 1'b0; tile_done = 1'b0;
        check("rd_bank_swap", 32'(rd_bank), 32'd0);
        check("wr_bank_swap", 32'(wr_bank), 32'd1);
        check("rbr_swap", 32'(read_bank_ready), 32'd1);
        check("wr_ready_swap", 32'(wr_ready), 32'd1);
        check("err_clean", 32'(addr_error), 32'd0);
        rd(8'd3, 1'b1, 8'h77);
        rd(8'd127, 1'b1, 8'h11);
        rd(8'd5, 1'b1, 8'h05);

        // Out-of-range write then read.
        wr(8'd200, 8'h99, 1'b0);
        check("err_after_bad_write", 32'(addr_error), 32'd1);
        rd(8'd130, 1'b1, 8'h00);
        tick(); tick();
        check("err_sticky", 32'(addr_error), 32'd1);
        check("rbr_after_bad", 32'(read_bank_ready), 32'd1);

        // Give data a nonzero value, then reset asynchronously mid-fill.
        rd(8'd5, 1'b1, 8'h05);
        wr(8'd0, 8'h5A, 1'b0);
        wr(8'd1, 8'h5B, 1'b0);
        check("data_before_reset", 32'(fibre_a_data), 32'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wr_ready", 32'(wr_ready), 32'd1);
        check("async_rbr", 32'(read_bank_ready), 32'd0);
        check("async_err", 32'(addr_error), 32'd0);
        check("async_data", 32'(fibre_a_data), 32'd0);
        check("async_banks", {30'd0, wr_bank, rd_bank}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Read with no sealed tile: no valid, error set.
        rd(8'd1, 1'b0, 8'h00);
        check("nosealed_valid", 32'(fibre_a_valid), 32'd0);
        check("nosealed_err", 32'(addr_error), 32'd1);

        tick(); tick(); tick();
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
